ws2812_frame_scheduler: RTL

Sequences one WS2812 frame at a time. It reads each pixel's 24-bit RGB word from the LED BRAM in address order and hands it to the bit serializer over a valid/ready handshake. After the last pixel it holds the latch (reset) gap. It sits between the config controller (num_leds, write_config), the BRAM read port and the serializer, and starts frames on a periodic refresh tick or on an explicit start request.

---
 rtl/ws2812_frame_scheduler.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ws2812_frame_scheduler.sv
// WS2812 frame scheduler: fetches pixel words from LED BRAM in address order,
// hands them to the serializer over valid/ready, then holds the latch gap.
// Ports: clk, rst (sync, active-high); write_config/num_leds (config in);
//   start (manual frame request); read_en/read_address/rgb_data_in (BRAM);
//   px_valid/px_data/px_ready (serializer); latch, busy, frame_done (status).
module ws2812_frame_scheduler #(
    parameter int ADDR_W       = 16,
    parameter int REFRESH_CLKS = 833333,
    parameter int RESET_CLKS   = 15000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_config,
    input  logic [ADDR_W-1:0] num_leds,
    input  logic              start,
    output logic              read_en,
    output logic [ADDR_W-1:0] read_address,
    input  logic [23:0]       rgb_data_in,
    output logic              px_valid,
    output logic [23:0]       px_data,
    input  logic              px_ready,
    output logic              latch,
    output logic              busy,
    output logic              frame_done
);

    localparam int RW = (REFRESH_CLKS > 1) ? $clog2(REFRESH_CLKS) : 1;
    localparam int GW = (RESET_CLKS > 1) ? $clog2(RESET_CLKS) : 1;
    localparam logic [RW-1:0]     REF_LAST = RW'(REFRESH_CLKS - 1);
    localparam logic [RW-1:0]     REF_ONE  = RW'(1);
    localparam logic [GW-1:0]     GAP_LAST = GW'(RESET_CLKS - 1);
    localparam logic [GW-1:0]     GAP_ONE  = GW'(1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_RD,
        PRESENT,
        LATCH
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] shadow;
    logic [ADDR_W-1:0] active;
    logic [ADDR_W-1:0] idx;
    logic [RW-1:0]     refresh_cnt;
    logic [GW-1:0]     gap_cnt;
    logic              configured;
    logic              pending;
    logic              pend_clear;
    logic              frame_start;
    logic              last;
    logic              wrap;

    assign wrap = (refresh_cnt == REF_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        read_en     = 1'b0;
        latch       = 1'b0;
        busy        = (state != IDLE);
        pend_clear  = 1'b0;
        frame_start = 1'b0;
        last        = (idx == active - ONE);
        unique case (state)
            IDLE: begin
                // A request with no usable config is dropped, not kept.
                if (pending) begin
                    pend_clear = 1'b1;
                    if (configured && shadow != '0) begin
                        frame_start = 1'b1;
                        state_next  = FETCH;
                    end
                end
            end
            FETCH: begin
                read_en    = 1'b1;
                state_next = WAIT_RD;
            end
            WAIT_RD: state_next = PRESENT;
            PRESENT: begin
                if (px_valid && px_ready) begin
                    state_next = last ? LATCH : FETCH;
                end
            end
            LATCH: begin
                latch = 1'b1;
                if (gap_cnt == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow       <= '0;
            active       <= '0;
            idx          <= '0;
            refresh_cnt  <= '0;
            gap_cnt      <= '0;
            configured   <= 1'b0;
            pending      <= 1'b0;
            read_address <= '0;
            px_valid     <= 1'b0;
            px_data      <= '0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (write_config) begin
                shadow     <= num_leds;
                configured <= 1'b1;
            end
            refresh_cnt <= wrap ? '0 : refresh_cnt + REF_ONE;
            // Requests coalesce into a single flag.
            pending <= (pending && !pend_clear) || start || wrap;
            unique case (state)
                IDLE: begin
                    // Old shadow is used even if write_config hits now.
                    if (frame_start) begin
                        active       <= shadow;
                        idx          <= '0;
                        read_address <= '0;
                    end
                end
                WAIT_RD: begin
                    px_data  <= rgb_data_in;
                    px_valid <= 1'b1;
                end
                PRESENT: begin
                    if (px_valid && px_ready) begin
                        px_valid <= 1'b0;
                        if (last) begin
                            gap_cnt <= GAP_LAST;
                        end else begin
                            idx          <= idx + ONE;
                            read_address <= idx + ONE;
                        end
                    end
                end
                LATCH: begin
                    if (gap_cnt == '0) begin
                        frame_done <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
